// File: rtl/rename_nway.sv
// rename_nway: WIDTH-wide register-rename stage between decode and dispatch.
// Renames a whole group per cycle against the external RAT and free list,
// resolves intra-group RAW/WAW hazards, and holds the result in a registered
// output stage with valid/ready backpressure.
// Optional feature macro: RENAME_STALL_CNT_EN builds the free-list and
// backpressure stall counters; without it both counter outputs are tied to 0.
module rename_nway #(
  parameter int WIDTH     = 2,
  parameter int LREG_W    = 5,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 128,
  parameter int FLCNT_W   = $clog2(WIDTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush_valid,
  input  logic [WIDTH-1:0]           in_valid,
  output logic                       in_ready,
  input  logic [WIDTH*LREG_W-1:0]    in_lrs1,
  input  logic [WIDTH*LREG_W-1:0]    in_lrs2,
  input  logic [WIDTH*LREG_W-1:0]    in_lrd,
  input  logic [WIDTH-1:0]           in_src1_is_reg,
  input  logic [WIDTH-1:0]           in_src2_is_reg,
  input  logic [WIDTH-1:0]           in_need_to_wb,
  input  logic [WIDTH*PAYLOAD_W-1:0] in_payload,
  input  logic [WIDTH*PREG_W-1:0]    rat_prs1,
  input  logic [WIDTH*PREG_W-1:0]    rat_prs2,
  input  logic [WIDTH*PREG_W-1:0]    rat_prd,
  output logic [WIDTH-1:0]           rat_wr_valid,
  output logic [WIDTH*LREG_W-1:0]    rat_wr_addr,
  output logic [WIDTH*PREG_W-1:0]    rat_wr_data,
  input  logic [FLCNT_W-1:0]         fl_avail,
  output logic [WIDTH-1:0]           fl_req,
  input  logic [WIDTH*PREG_W-1:0]    fl_resp,
  output logic [WIDTH-1:0]           out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*LREG_W-1:0]    out_lrd,
  output logic [WIDTH*PREG_W-1:0]    out_prs1,
  output logic [WIDTH*PREG_W-1:0]    out_prs2,
  output logic [WIDTH*PREG_W-1:0]    out_prd,
  output logic [WIDTH*PREG_W-1:0]    out_old_prd,
  output logic [WIDTH-1:0]           out_need_to_wb,
  output logic [WIDTH*PAYLOAD_W-1:0] out_payload,
  output logic [31:0]                stall_fl_cnt,
  output logic [31:0]                stall_bp_cnt
);

  logic [WIDTH-1:0]           alloc;
  logic [FLCNT_W-1:0]         need;
  logic                       fire;
  logic [WIDTH*PREG_W-1:0]    prs1_c, prs2_c, prd_c, old_prd_c;
  logic [WIDTH-1:0]           rat_wr_c;

  logic [WIDTH-1:0]           out_valid_q, out_valid_d;
  logic [WIDTH*LREG_W-1:0]    out_lrd_q, out_lrd_d;
  logic [WIDTH*PREG_W-1:0]    out_prs1_q, out_prs1_d;
  logic [WIDTH*PREG_W-1:0]    out_prs2_q, out_prs2_d;
  logic [WIDTH*PREG_W-1:0]    out_prd_q, out_prd_d;
  logic [WIDTH*PREG_W-1:0]    out_old_prd_q, out_old_prd_d;
  logic [WIDTH-1:0]           out_need_to_wb_q, out_need_to_wb_d;
  logic [WIDTH*PAYLOAD_W-1:0] out_payload_q, out_payload_d;

  // Allocation demand and whole-group handshake: a group goes only if every allocating slot gets a preg
  always_comb begin
    alloc = '0;
    need  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      alloc[i] = in_valid[i] & in_need_to_wb[i] & (in_lrd[i*LREG_W +: LREG_W] != '0);
      need     = need + FLCNT_W'(alloc[i]);
    end
    in_ready = ~flush_valid & (~out_valid_q[0] | out_ready) & (fl_avail >= need);
    fire     = (|in_valid) & in_ready;
  end

  // Rename: older in-group writers override the RAT; the youngest such writer wins; x0 sources read 0
  always_comb begin
    prs1_c    = rat_prs1;
    prs2_c    = rat_prs2;
    prd_c     = '0;
    old_prd_c = '0;
    rat_wr_c  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (alloc[i]) begin
        prd_c[i*PREG_W +: PREG_W]     = fl_resp[i*PREG_W +: PREG_W];
        old_prd_c[i*PREG_W +: PREG_W] = rat_prd[i*PREG_W +: PREG_W];
      end
      for (int j = 0; j < WIDTH; j++) begin
        if (j < i && alloc[j]) begin
          if (in_lrd[j*LREG_W +: LREG_W] == in_lrs1[i*LREG_W +: LREG_W])
            prs1_c[i*PREG_W +: PREG_W] = fl_resp[j*PREG_W +: PREG_W];
          if (in_lrd[j*LREG_W +: LREG_W] == in_lrs2[i*LREG_W +: LREG_W])
            prs2_c[i*PREG_W +: PREG_W] = fl_resp[j*PREG_W +: PREG_W];
          if (alloc[i] && (in_lrd[j*LREG_W +: LREG_W] == in_lrd[i*LREG_W +: LREG_W]))
            old_prd_c[i*PREG_W +: PREG_W] = fl_resp[j*PREG_W +: PREG_W];
        end
      end
      if (in_src1_is_reg[i] && (in_lrs1[i*LREG_W +: LREG_W] == '0))
        prs1_c[i*PREG_W +: PREG_W] = '0;
      if (in_src2_is_reg[i] && (in_lrs2[i*LREG_W +: LREG_W] == '0))
        prs2_c[i*PREG_W +: PREG_W] = '0;
      rat_wr_c[i] = alloc[i] & fire;
      for (int k = 0; k < WIDTH; k++) begin
        if (k > i && alloc[k] && (in_lrd[k*LREG_W +: LREG_W] == in_lrd[i*LREG_W +: LREG_W]))
          rat_wr_c[i] = 1'b0;
      end
    end
  end

  assign fl_req       = alloc & {WIDTH{fire}};
  assign rat_wr_valid = rat_wr_c;
  assign rat_wr_addr  = in_lrd;
  assign rat_wr_data  = fl_resp;

  // Output stage next state: flush drops the group, fire loads a new one, a drained group clears, otherwise hold
  always_comb begin
    out_valid_d      = out_valid_q;
    out_lrd_d        = out_lrd_q;
    out_prs1_d       = out_prs1_q;
    out_prs2_d       = out_prs2_q;
    out_prd_d        = out_prd_q;
    out_old_prd_d    = out_old_prd_q;
    out_need_to_wb_d = out_need_to_wb_q;
    out_payload_d    = out_payload_q;
    if (flush_valid) begin
      out_valid_d = '0;
    end else if (fire) begin
      out_valid_d      = in_valid;
      out_lrd_d        = in_lrd;
      out_prs1_d       = prs1_c;
      out_prs2_d       = prs2_c;
      out_prd_d        = prd_c;
      out_old_prd_d    = old_prd_c;
      out_need_to_wb_d = in_need_to_wb;
      out_payload_d    = in_payload;
    end else if (out_valid_q[0] && out_ready) begin
      out_valid_d = '0;
    end
  end

  // Output stage registers
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q      <= '0;
      out_lrd_q        <= '0;
      out_prs1_q       <= '0;
      out_prs2_q       <= '0;
      out_prd_q        <= '0;
      out_old_prd_q    <= '0;
      out_need_to_wb_q <= '0;
      out_payload_q    <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_lrd_q        <= out_lrd_d;
      out_prs1_q       <= out_prs1_d;
      out_prs2_q       <= out_prs2_d;
      out_prd_q        <= out_prd_d;
      out_old_prd_q    <= out_old_prd_d;
      out_need_to_wb_q <= out_need_to_wb_d;
      out_payload_q    <= out_payload_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_lrd        = out_lrd_q;
  assign out_prs1       = out_prs1_q;
  assign out_prs2       = out_prs2_q;
  assign out_prd        = out_prd_q;
  assign out_old_prd    = out_old_prd_q;
  assign out_need_to_wb = out_need_to_wb_q;
  assign out_payload    = out_payload_q;

`ifdef RENAME_STALL_CNT_EN
  logic [31:0] stall_fl_cnt_q, stall_fl_cnt_d;
  logic [31:0] stall_bp_cnt_q, stall_bp_cnt_d;
  logic        bp_stall, fl_stall;

  // Stall accounting: backpressure masks a simultaneous free-list shortage; flush clears both
  always_comb begin
    bp_stall       = out_valid_q[0] & ~out_ready;
    fl_stall       = ~bp_stall & (|in_valid) & (fl_avail < need);
    stall_fl_cnt_d = stall_fl_cnt_q;
    stall_bp_cnt_d = stall_bp_cnt_q;
    if (flush_valid) begin
      stall_fl_cnt_d = '0;
      stall_bp_cnt_d = '0;
    end else if (bp_stall) begin
      stall_bp_cnt_d = stall_bp_cnt_q + 32'd1;
    end else if (fl_stall) begin
      stall_fl_cnt_d = stall_fl_cnt_q + 32'd1;
    end
  end

  // Stall counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_fl_cnt_q <= '0;
      stall_bp_cnt_q <= '0;
    end else begin
      stall_fl_cnt_q <= stall_fl_cnt_d;
      stall_bp_cnt_q <= stall_bp_cnt_d;
    end
  end

  assign stall_fl_cnt = stall_fl_cnt_q;
  assign stall_bp_cnt = stall_bp_cnt_q;
`else
  assign stall_fl_cnt = '0;
  assign stall_bp_cnt = '0;
`endif

endmodule

// File: tb/tb_rename_nway.sv
// tb_rename_nway: scoreboard bench for rename_nway. The driver renames each
// group with a slot-by-slot walk over a logical->physical map and keeps its
// own RAT array; accepted groups are queued and a negedge monitor pops and
// compares whenever the DUT presents a group.
module tb_rename_nway;

  localparam int WIDTH     = 2;
  localparam int LREG_W    = 5;
  localparam int PREG_W    = 6;
  localparam int PAYLOAD_W = 128;
  localparam int FLCNT_W   = $clog2(WIDTH + 1);
  localparam int NLREG     = 2 ** LREG_W;

  logic clock = 1'b0;
  logic reset;
  logic flush_valid;
  logic [WIDTH-1:0]           in_valid;
  logic                       in_ready;
  logic [WIDTH*LREG_W-1:0]    in_lrs1, in_lrs2, in_lrd;
  logic [WIDTH-1:0]           in_src1_is_reg, in_src2_is_reg, in_need_to_wb;
  logic [WIDTH*PAYLOAD_W-1:0] in_payload;
  logic [WIDTH*PREG_W-1:0]    rat_prs1, rat_prs2, rat_prd;
  logic [WIDTH-1:0]           rat_wr_valid;
  logic [WIDTH*LREG_W-1:0]    rat_wr_addr;
  logic [WIDTH*PREG_W-1:0]    rat_wr_data;
  logic [FLCNT_W-1:0]         fl_avail;
  logic [WIDTH-1:0]           fl_req;
  logic [WIDTH*PREG_W-1:0]    fl_resp;
  logic [WIDTH-1:0]           out_valid;
  logic                       out_ready;
  logic [WIDTH*LREG_W-1:0]    out_lrd;
  logic [WIDTH*PREG_W-1:0]    out_prs1, out_prs2, out_prd, out_old_prd;
  logic [WIDTH-1:0]           out_need_to_wb;
  logic [WIDTH*PAYLOAD_W-1:0] out_payload;
  logic [31:0]                stall_fl_cnt, stall_bp_cnt;

  always #5 clock = ~clock;

  rename_nway #(
    .WIDTH(WIDTH), .LREG_W(LREG_W), .PREG_W(PREG_W),
    .PAYLOAD_W(PAYLOAD_W), .FLCNT_W(FLCNT_W)
  ) dut (
    .clock(clock), .reset(reset), .flush_valid(flush_valid),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lrs1(in_lrs1), .in_lrs2(in_lrs2), .in_lrd(in_lrd),
    .in_src1_is_reg(in_src1_is_reg), .in_src2_is_reg(in_src2_is_reg),
    .in_need_to_wb(in_need_to_wb), .in_payload(in_payload),
    .rat_prs1(rat_prs1), .rat_prs2(rat_prs2), .rat_prd(rat_prd),
    .rat_wr_valid(rat_wr_valid), .rat_wr_addr(rat_wr_addr), .rat_wr_data(rat_wr_data),
    .fl_avail(fl_avail), .fl_req(fl_req), .fl_resp(fl_resp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lrd(out_lrd), .out_prs1(out_prs1), .out_prs2(out_prs2),
    .out_prd(out_prd), .out_old_prd(out_old_prd),
    .out_need_to_wb(out_need_to_wb), .out_payload(out_payload),
    .stall_fl_cnt(stall_fl_cnt), .stall_bp_cnt(stall_bp_cnt)
  );

  typedef struct packed {
    logic [WIDTH-1:0]           valid;
    logic [WIDTH*LREG_W-1:0]    lrd;
    logic [WIDTH*PREG_W-1:0]    prs1;
    logic [WIDTH*PREG_W-1:0]    prs2;
    logic [WIDTH*PREG_W-1:0]    prd;
    logic [WIDTH*PREG_W-1:0]    old_prd;
    logic [WIDTH-1:0]           nwb;
    logic [WIDTH*PAYLOAD_W-1:0] payload;
  } exp_t;

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];

  // Per-cycle stimulus, one entry per slot
  logic [WIDTH-1:0]     cur_valid, cur_src1_is_reg, cur_src2_is_reg, cur_nwb;
  logic [LREG_W-1:0]    cur_lrs1 [WIDTH];
  logic [LREG_W-1:0]    cur_lrs2 [WIDTH];
  logic [LREG_W-1:0]    cur_lrd  [WIDTH];
  logic [PREG_W-1:0]    cur_resp [WIDTH];
  logic [PAYLOAD_W-1:0] cur_payload [WIDTH];
  logic [FLCNT_W-1:0]   cur_avail;
  logic                 cur_flush, cur_out_ready;

  // Reference state: architectural RAT, expected out_valid, expected counters
  logic [PREG_W-1:0] rat [NLREG];
  logic [WIDTH-1:0]  m_valid;
  int unsigned       m_fl_cnt, m_bp_cnt;

  // Shared comparison point; every failure prints one FAIL line
  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic clearInputs();
    cur_valid = '0; cur_src1_is_reg = '0; cur_src2_is_reg = '0; cur_nwb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cur_lrs1[i] = '0; cur_lrs2[i] = '0; cur_lrd[i] = '0;
      cur_resp[i] = '0; cur_payload[i] = '0;
    end
    cur_avail = FLCNT_W'(WIDTH); cur_flush = 1'b0; cur_out_ready = 1'b1;
  endtask

  task automatic driveInputs();
    flush_valid    = cur_flush;
    out_ready      = cur_out_ready;
    fl_avail       = cur_avail;
    in_valid       = cur_valid;
    in_src1_is_reg = cur_src1_is_reg;
    in_src2_is_reg = cur_src2_is_reg;
    in_need_to_wb  = cur_nwb;
    for (int i = 0; i < WIDTH; i++) begin
      in_lrs1[i*LREG_W +: LREG_W]        = cur_lrs1[i];
      in_lrs2[i*LREG_W +: LREG_W]        = cur_lrs2[i];
      in_lrd[i*LREG_W +: LREG_W]         = cur_lrd[i];
      in_payload[i*PAYLOAD_W +: PAYLOAD_W] = cur_payload[i];
      fl_resp[i*PREG_W +: PREG_W]        = cur_resp[i];
      rat_prs1[i*PREG_W +: PREG_W]       = rat[cur_lrs1[i]];
      rat_prs2[i*PREG_W +: PREG_W]       = rat[cur_lrs2[i]];
      rat_prd[i*PREG_W +: PREG_W]        = rat[cur_lrd[i]];
    end
  endtask

  // One cycle: drive, predict with a sequential map walk, check handshake outputs, queue accepted group
  task automatic applyStimulus();
    logic [WIDTH-1:0]  alloc, e_wr;
    logic [PREG_W-1:0] map_p [NLREG];
    bit                map_v [NLREG];
    int                last_w [NLREG];
    int                need;
    bit                e_ready, e_fire, bp, fls;
    exp_t              e;
    @(posedge clock); #1;
    driveInputs();
    #1;
    need = 0;
    for (int i = 0; i < WIDTH; i++) begin
      alloc[i] = cur_valid[i] && cur_nwb[i] && (cur_lrd[i] != 0);
      need += int'(alloc[i]);
    end
    e_ready = !cur_flush && (m_valid == 0 || cur_out_ready) && (int'(cur_avail) >= need);
    e_fire  = (cur_valid != 0) && e_ready;
    for (int r = 0; r < NLREG; r++) begin
      map_v[r] = 1'b0; map_p[r] = '0; last_w[r] = -1;
    end
    e = '0;
    e.valid = cur_valid;
    e.nwb   = cur_nwb;
    for (int i = 0; i < WIDTH; i++) begin
      e.lrd[i*LREG_W +: LREG_W]           = cur_lrd[i];
      e.payload[i*PAYLOAD_W +: PAYLOAD_W] = cur_payload[i];
      if (cur_src1_is_reg[i] && cur_lrs1[i] == 0) e.prs1[i*PREG_W +: PREG_W] = '0;
      else if (map_v[cur_lrs1[i]])                e.prs1[i*PREG_W +: PREG_W] = map_p[cur_lrs1[i]];
      else                                        e.prs1[i*PREG_W +: PREG_W] = rat[cur_lrs1[i]];
      if (cur_src2_is_reg[i] && cur_lrs2[i] == 0) e.prs2[i*PREG_W +: PREG_W] = '0;
      else if (map_v[cur_lrs2[i]])                e.prs2[i*PREG_W +: PREG_W] = map_p[cur_lrs2[i]];
      else                                        e.prs2[i*PREG_W +: PREG_W] = rat[cur_lrs2[i]];
      if (alloc[i]) begin
        e.old_prd[i*PREG_W +: PREG_W] = map_v[cur_lrd[i]] ? map_p[cur_lrd[i]] : rat[cur_lrd[i]];
        e.prd[i*PREG_W +: PREG_W]     = cur_resp[i];
        map_v[cur_lrd[i]]  = 1'b1;
        map_p[cur_lrd[i]]  = cur_resp[i];
        last_w[cur_lrd[i]] = i;
      end
    end
    for (int i = 0; i < WIDTH; i++)
      e_wr[i] = e_fire && alloc[i] && (last_w[cur_lrd[i]] == i);
    checkOutput("in_ready", in_ready, e_ready);
    checkOutput("fl_req", fl_req, e_fire ? alloc : '0);
    checkOutput("rat_wr_valid", rat_wr_valid, e_wr);
    checkOutput("out_valid", out_valid, m_valid);
    checkOutput("stall_fl_cnt", stall_fl_cnt, m_fl_cnt);
    checkOutput("stall_bp_cnt", stall_bp_cnt, m_bp_cnt);
    for (int i = 0; i < WIDTH; i++) begin
      if (e_wr[i]) begin
        checkOutput("rat_wr_addr", rat_wr_addr[i*LREG_W +: LREG_W], cur_lrd[i]);
        checkOutput("rat_wr_data", rat_wr_data[i*PREG_W +: PREG_W], cur_resp[i]);
      end
    end
    bp  = (m_valid != 0) && !cur_out_ready;
    fls = !bp && (cur_valid != 0) && (int'(cur_avail) < need);
`ifdef RENAME_STALL_CNT_EN
    if (cur_flush) begin
      m_fl_cnt = 0; m_bp_cnt = 0;
    end else if (bp) begin
      m_bp_cnt++;
    end else if (fls) begin
      m_fl_cnt++;
    end
`else
    if (bp || fls) begin
      m_fl_cnt = 0; m_bp_cnt = 0;
    end
`endif
    if (cur_flush)                            m_valid = '0;
    else if (e_fire)                          m_valid = cur_valid;
    else if (m_valid != 0 && cur_out_ready)   m_valid = '0;
    if (e_fire) begin
      sb_q.push_back(e);
      for (int i = 0; i < WIDTH; i++)
        if (alloc[i]) rat[cur_lrd[i]] = cur_resp[i];
    end
  endtask

  // Monitor: pop a new expected group when one is first presented, re-check it every cycle it is held
  exp_t cur_exp;
  bit   have_exp  = 1'b0;
  bit   presented = 1'b0;
  always @(negedge clock) begin
    if (reset !== 1'b0) begin
      presented = 1'b0;
    end else begin
      if (out_valid != 0) begin
        if (!presented) begin
          if (sb_q.size() == 0) begin
            checks++; failures++; have_exp = 1'b0;
            $display("[TB] FAIL unexpected_group actual=%0h required=none", out_valid);
          end else begin
            cur_exp  = sb_q.pop_front();
            have_exp = 1'b1;
          end
        end
        if (have_exp) begin
          checkOutput("mon_valid", out_valid, cur_exp.valid);
          checkOutput("mon_lrd", out_lrd, cur_exp.lrd);
          checkOutput("mon_prs1", out_prs1, cur_exp.prs1);
          checkOutput("mon_prs2", out_prs2, cur_exp.prs2);
          checkOutput("mon_prd", out_prd, cur_exp.prd);
          checkOutput("mon_old_prd", out_old_prd, cur_exp.old_prd);
          checkOutput("mon_need_to_wb", out_need_to_wb, cur_exp.nwb);
          checkOutput("mon_payload", out_payload, cur_exp.payload);
        end
      end
      presented = (out_valid != 0) && !out_ready && !flush_valid;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [LREG_W-1:0] tmp_lrd;

  initial begin
    for (int r = 0; r < NLREG; r++) rat[r] = PREG_W'(r);
    m_valid = '0; m_fl_cnt = 0; m_bp_cnt = 0;
    clearInputs();
    reset = 1'b1;
    driveInputs();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    driveInputs();
    #1;
    checkOutput("reset_out_valid", out_valid, '0);
    checkOutput("reset_out_data", {out_lrd, out_prs1, out_prs2, out_prd, out_old_prd, out_need_to_wb}, '0);
    checkOutput("reset_out_payload", out_payload, '0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_counters", {stall_fl_cnt, stall_bp_cnt}, '0);

    // RAW: slot0 writes x5, slot1 reads x5
    clearInputs();
    rat[5] = 6'd3;
    cur_valid = 2'b11; cur_nwb = 2'b01; cur_lrd[0] = 5'd5;
    cur_src1_is_reg = 2'b10; cur_lrs1[1] = 5'd5; cur_lrs1[0] = 5'd1;
    cur_resp[0] = 6'd9; cur_resp[1] = 6'd12;
    cur_nwb[1] = 1'b1; cur_lrd[1] = 5'd6;
    cur_payload[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus();
    checkOutput("raw_rat_wr_valid", rat_wr_valid, 2'b11);
    clearInputs();
    applyStimulus();
    checkOutput("raw_out_prs1_1", out_prs1[PREG_W +: PREG_W], 6'd9);
    checkOutput("raw_out_prd", out_prd, {6'd12, 6'd9});

    // WAW: both slots write x7
    clearInputs();
    rat[7] = 6'd4;
    cur_valid = 2'b11; cur_nwb = 2'b11; cur_lrd[0] = 5'd7; cur_lrd[1] = 5'd7;
    cur_resp[0] = 6'd20; cur_resp[1] = 6'd21;
    applyStimulus();
    checkOutput("waw_rat_wr_valid", rat_wr_valid, 2'b10);
    checkOutput("waw_rat_wr_data1", rat_wr_data[PREG_W +: PREG_W], 6'd21);
    clearInputs();
    applyStimulus();
    checkOutput("waw_old_prd", out_old_prd, {6'd20, 6'd4});

    // Free-list shortage: 3 stalled cycles then accepted
    for (int c = 0; c < 4; c++) begin
      clearInputs();
      cur_valid = 2'b11; cur_nwb = 2'b11; cur_lrd[0] = 5'd3; cur_lrd[1] = 5'd4;
      cur_resp[0] = 6'd30; cur_resp[1] = 6'd31;
      cur_avail = (c < 3) ? 2'd1 : 2'd2;
      applyStimulus();
      if (c == 3) begin
`ifdef RENAME_STALL_CNT_EN
        checkOutput("fl_stall_cnt_3", stall_fl_cnt, 32'd3);
`else
        checkOutput("fl_stall_cnt_off", stall_fl_cnt, 32'd0);
`endif
        checkOutput("fl_group_accepted", fl_req, 2'b11);
      end
    end

    // Backpressure hold for 2 cycles, then flush
    for (int c = 0; c < 2; c++) begin
      clearInputs();
      cur_valid = 2'b01; cur_out_ready = 1'b0;
      applyStimulus();
    end
    clearInputs();
    cur_flush = 1'b1; cur_out_ready = 1'b0; cur_valid = 2'b01;
    applyStimulus();
`ifdef RENAME_STALL_CNT_EN
    checkOutput("bp_stall_cnt_2", stall_bp_cnt, 32'd2);
`else
    checkOutput("bp_stall_cnt_off", stall_bp_cnt, 32'd0);
`endif
    clearInputs();
    applyStimulus();
    checkOutput("flush_out_valid", out_valid, '0);

    // x0 destination and x0 source
    clearInputs();
    cur_valid = 2'b01; cur_nwb = 2'b01; cur_src1_is_reg = 2'b01;
    cur_resp[0] = 6'd40;
    applyStimulus();
    checkOutput("x0_fl_req0", fl_req[0], 1'b0);
    checkOutput("x0_rat_wr0", rat_wr_valid[0], 1'b0);
    clearInputs();
    applyStimulus();
    checkOutput("x0_out_prd0", out_prd[0 +: PREG_W], 6'd0);
    checkOutput("x0_out_prs10", out_prs1[0 +: PREG_W], 6'd0);

    // Randomized traffic with small register range to provoke hazards
    for (int n = 0; n < 600; n++) begin
      clearInputs();
      case ($urandom_range(0, 3))
        0:       cur_valid = 2'b00;
        1:       cur_valid = 2'b01;
        default: cur_valid = 2'b11;
      endcase
      for (int i = 0; i < WIDTH; i++) begin
        cur_lrs1[i]    = LREG_W'($urandom_range(0, 7));
        cur_lrs2[i]    = LREG_W'($urandom_range(0, 7));
        tmp_lrd        = LREG_W'($urandom_range(0, 7));
        cur_lrd[i]     = tmp_lrd;
        cur_resp[i]    = PREG_W'($urandom());
        cur_payload[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      cur_src1_is_reg = WIDTH'($urandom_range(0, 3));
      cur_src2_is_reg = WIDTH'($urandom_range(0, 3));
      cur_nwb         = WIDTH'($urandom_range(0, 3));
      cur_avail       = ($urandom_range(0, 3) == 0) ? FLCNT_W'($urandom_range(0, 1)) : FLCNT_W'(2);
      cur_out_ready   = ($urandom_range(0, 3) != 0);
      cur_flush       = ($urandom_range(0, 19) == 0);
      applyStimulus();
    end

    // Drain
    for (int c = 0; c < 3; c++) begin
      clearInputs();
      applyStimulus();
    end
    checkOutput("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_nway.md
# rename_nway

Parametrised N-wide register-rename stage between decode and dispatch. It renames up to WIDTH instructions per cycle against the RAT and free list, and resolves intra-group RAW and WAW dependencies. Results are held in a registered output stage with valid/ready backpressure. The block adds free-list-shortage stall, x0 bypass and flush handling.

## Interface
- WIDTH, 2: instructions per group (slot 0 oldest).
- LREG_W, 5: logical register index width.
- PREG_W, 6: physical register index width.
- PAYLOAD_W, 128: opaque per-slot payload (pc, imm, types), passed through unchanged.
- FLCNT_W, $clog2(WIDTH+1): free-list availability count width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush_valid  in  1  pipeline flush.
- in_valid  in  WIDTH  per-slot valid; valid slots are contiguous from slot 0.
- in_ready  out  1  group accepted this cycle.
- in_lrs1, in_lrs2, in_lrd  in  WIDTH*LREG_W  logical sources and destination.
- in_src1_is_reg, in_src2_is_reg, in_need_to_wb  in  WIDTH  operand/dest usage.
- in_payload  in  WIDTH*PAYLOAD_W  passthrough.
- rat_prs1, rat_prs2, rat_prd  in  WIDTH*PREG_W  combinational RAT lookups of in_lrs1/in_lrs2/in_lrd.
- rat_wr_valid  out  WIDTH; rat_wr_addr  out  WIDTH*LREG_W; rat_wr_data  out  WIDTH*PREG_W.
- fl_avail  in  FLCNT_W  min(free pregs, WIDTH).
- fl_req  out  WIDTH; fl_resp  in  WIDTH*PREG_W  preg for slot i, valid same cycle as fl_req[i].
- out_valid  out  WIDTH; out_ready  in  1.
- out_lrd  out  WIDTH*LREG_W; out_prs1, out_prs2, out_prd, out_old_prd  out  WIDTH*PREG_W; out_need_to_wb  out  WIDTH; out_payload  out  WIDTH*PAYLOAD_W.
- stall_fl_cnt, stall_bp_cnt  out  32 each  performance counters (see Configuration).

## Operation
- alloc[i] = in_valid[i] & in_need_to_wb[i] & (in_lrd[i] != 0). x0 destinations never allocate; their prd and old_prd are 0.
- need = popcount(alloc). fire = |in_valid & in_ready.
- in_ready = ~flush_valid & (~out_valid[0] | out_ready) & (fl_avail >= need).
- fl_req[i] = alloc[i] & fire. Groups are all-or-nothing; there are no partial groups.
- Source renaming for slot i, src1 (src2 identical): if src1_is_reg & lrs1 == 0, prs1 = 0. Otherwise take fl_resp[j] of the youngest j < i with alloc[j] and lrd[j] == lrs1. If no such j, take rat_prs1[i].
- old_prd[i]: fl_resp[j] of the youngest older j < i writing the same lrd. If none, rat_prd[i].
- RAT write: rat_wr_valid[i] = alloc[i] & fire & no younger k > i with alloc[k] and lrd[k] == lrd[i]. Only the final WAW writer updates the RAT. Addr = lrd[i], data = fl_resp[i].
- Output register:
  - Loads all slots on fire; out_valid = in_valid.
  - Clears to 0 when out_valid & out_ready & ~fire.
  - Holds while ~out_ready.
- Flush:
  - in_ready = 0; no fl_req and no RAT write.
  - out_valid cleared on the next edge. Flush has priority over fire and hold.
- Reset: out_valid = 0, all out_* data = 0, counters = 0. in_ready follows the combinational equation once reset deasserts.

## Timing
- Latency: 1 cycle. A group accepted at edge N is on out_* after edge N.
- Throughput: 1 group/cycle when out_ready = 1 and fl_avail >= need.
- RAT, free list and rename logic are combinational within the accepting cycle. The RAT update is visible to the next group's lookup on the following cycle.
- Simultaneous flush with out_ready = 1 and in_valid: nothing accepted; out_valid = 0 next cycle.
- fl_avail < need: group stalls whole; stall_fl_cnt increments.
- out_valid & ~out_ready: stall_bp_cnt increments. If both stall conditions hold, only stall_bp_cnt increments.

## Configuration
- RENAME_STALL_CNT_EN defined: stall_fl_cnt and stall_bp_cnt count as above, wrap at 2^32 and clear on reset or flush_valid.
- RENAME_STALL_CNT_EN undefined: both outputs tied to 0 and no counter flops exist.

## Test plan
- Reset for 3 cycles, then release with in_valid = 0 -> out_valid = 0, all out_* = 0, in_ready = 1 (fl_avail = 2, out_ready = 1).
- WIDTH = 2, slot0 writes x5, slot1 reads x5 as src1; fl_resp = {12, 9}, rat_prs1[1] = 3 -> out_prs1[1] = 9, out_prd = {12, 9}, rat_wr_valid = 2'b11.
- WAW: both slots write x7, rat_prd = {4, 4}, fl_resp = {21, 20} -> rat_wr_valid = 2'b10 with data 21; out_old_prd[1] = 20, out_old_prd[0] = 4.
- Both slots write with fl_avail = 1 for 3 cycles, then 2 -> in_ready = 0, fl_req = 0 for 3 cycles, stall_fl_cnt = 3, then the group is accepted.
- out_ready = 0 for 2 cycles while out_valid -> out_* stable, in_ready = 0, stall_bp_cnt = 2; flush_valid pulse -> out_valid = 0 next cycle, counters = 0.
- Slot 0 with lrd = x0, need_to_wb = 1, src1 = x0 -> fl_req[0] = 0, out_prd[0] = 0, out_prs1[0] = 0, rat_wr_valid[0] = 0.
